// File: rtl/simple_intt_core.sv
// 4-point inverse NTT over q = 12289: loads four coefficients, runs a 20-cycle
// serial MAC/scale schedule, then drains the four time-domain results.
module simple_intt_core #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam logic [13:0] Q     = 14'd12289;
    localparam logic [13:0] N_INV = 14'd9217;

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

    state_t      state;
    logic [13:0] a [4];
    logic [13:0] r [4];
    logic [13:0] acc;
    logic [1:0]  load_cnt;
    logic [1:0]  out_cnt;
    logic [1:0]  j_cnt;
    logic [2:0]  step;

    function automatic logic [13:0] w_inv(input logic [1:0] k);
        case (k)
            2'd0:    w_inv = 14'd1;
            2'd1:    w_inv = 14'd10810;
            2'd2:    w_inv = 14'd12288;
            default: w_inv = 14'd1479;
        endcase
    endfunction

    logic [data_width-1:0] in_mod;
    logic [13:0]           in_red;
    logic [1:0]            tw_idx;
    logic [27:0]           mac_prod;
    logic [13:0]           mac_red;
    logic [14:0]           mac_sum;
    logic [13:0]           mac_next;
    logic [27:0]           scale_prod;
    logic [13:0]           scale_red;

    assign in_mod = in_data % data_width'(12289);
    assign in_red = 14'(in_mod);

    // (i*j) mod 4 falls out of the 2-bit truncation of the product
    assign tw_idx     = step[1:0] * j_cnt;
    assign mac_prod   = 28'(a[step[1:0]]) * 28'(w_inv(tw_idx));
    assign mac_red    = 14'(mac_prod % 28'(Q));
    assign mac_sum    = {1'b0, acc} + {1'b0, mac_red};
    assign mac_next   = (mac_sum >= 15'(Q)) ? 14'(mac_sum - 15'(Q)) : mac_sum[13:0];
    assign scale_prod = 28'(acc) * 28'(N_INV);
    assign scale_red  = 14'(scale_prod % 28'(Q));

    assign out_data = out_valid ? data_width'(r[out_cnt]) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            load_cnt  <= '0;
            out_cnt   <= '0;
            j_cnt     <= '0;
            step      <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                a[k] <= '0;
                r[k] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        a[load_cnt] <= in_red;
                        load_cnt    <= load_cnt + 2'd1;
                        if (load_cnt == 2'd3) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            step     <= '0;
                            j_cnt    <= '0;
                            acc      <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    // steps 0..3 accumulate A_i*w, step 4 scales by n^-1
                    if (step == 3'd4) begin
                        r[j_cnt] <= scale_red;
                        acc      <= '0;
                        step     <= '0;
                        j_cnt    <= j_cnt + 2'd1;
                        if (j_cnt == 2'd3) begin
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_cnt   <= '0;
                        end
                    end else begin
                        acc  <= mac_next;
                        step <= step + 3'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        out_cnt <= out_cnt + 2'd1;
                        if (out_cnt == 2'd3) begin
                            state     <= LOAD;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            load_cnt  <= '0;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_simple_intt_core.sv
// Directed bench for simple_intt_core: known transform vectors, stalls, resets
// and back-to-back streaming, each scenario checking its own results.
module tb_simple_intt_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got [4];

    simple_intt_core #(.data_width(32)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3, input bit gaps);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            in_data  = w[i];
            in_valid = 1'b1;
            tick();
            if (gaps && i < 3) begin
                in_valid = 1'b0;
                in_data  = 32'd999;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    // cycle 1 is the cycle right after the edge that took A_3
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain4();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got[k] = out_valid ? out_data : 32'hdead_beef;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b data=%0d exp 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_impulse();
        int lat;
        load4(32'd1, 32'd0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL impulse_compute_flags got rdy=%b busy=%b exp 0 1", in_ready, busy);
        end
        wait_out(lat);
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL impulse_latency got %0d exp 21", lat);
        end
        drain4();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 32'd9217) begin
                errors++;
                $display("FAIL impulse_out%0d got %0d exp 9217", k, got[k]);
            end
        end
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL impulse_idle got rdy=%b vld=%b busy=%b data=%0d exp 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_twiddle();
        int lat;
        logic [31:0] exp_v [4];
        exp_v = '{32'd1, 32'd10810, 32'd12288, 32'd1479};
        load4(32'd0, 32'd4, 32'd0, 32'd0, 1'b0);
        wait_out(lat);
        drain4();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL twiddle_out%0d got %0d exp %0d", k, got[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic [31:0] exp_v [4];
        exp_v = '{32'd4, 32'd0, 32'd0, 32'd0};
        load4(32'd12293, 32'd12293, 32'd12293, 32'd12293, 1'b0);
        wait_out(lat);
        drain4();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL wrap_out%0d got %0d exp %0d", k, got[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        int rcv;
        bit rdy;
        logic [31:0] prev;
        logic        prevv;
        logic [31:0] exp_v [4];
        exp_v = '{32'd4, 32'd0, 32'd0, 32'd0};
        load4(32'd4, 32'd4, 32'd4, 32'd4, 1'b1);
        wait_out(lat);
        rcv = 0;
        for (int c = 0; c < 40 && rcv < 4; c++) begin
            rdy       = (c % 4 == 0) || (c % 4 == 3);
            out_ready = rdy;
            in_valid  = 1'b1;         // must be ignored while draining
            in_data   = 32'd77;
            prev      = out_data;
            prevv     = out_valid;
            tick();
            if (rdy && prevv) begin
                got[rcv] = prev;
                rcv++;
            end else if (!rdy) begin
                checks++;
                if (out_data !== prev || out_valid !== prevv) begin
                    errors++;
                    $display("FAIL stall_hold got %0d/%b exp %0d/%b", out_data, out_valid, prev, prevv);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (rcv != 4) begin
            errors++;
            $display("FAIL stall_count got %0d exp 4", rcv);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL stall_out%0d got %0d exp %0d", k, got[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_reset_partial();
        int lat;
        in_data = 32'd5; in_valid = 1'b1; tick();
        in_data = 32'd6; tick();
        in_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        load4(32'd1, 32'd0, 32'd0, 32'd0, 1'b0);
        wait_out(lat);
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL partial_latency got %0d exp 21", lat);
        end
        drain4();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 32'd9217) begin
                errors++;
                $display("FAIL partial_out%0d got %0d exp 9217", k, got[k]);
            end
        end
    endtask

    task automatic test_reset_drain();
        int lat;
        load4(32'd0, 32'd4, 32'd0, 32'd0, 1'b0);
        wait_out(lat);
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_data !== 32'd10810) begin
            errors++;
            $display("FAIL drain_second got %0d exp 10810", out_data);
        end
        reset = 1'b1;            // handshake still asserted; reset must win
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL drain_reset got rdy=%b vld=%b busy=%b data=%0d exp 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] exp2 [4];
        exp2 = '{32'd1, 32'd10810, 32'd12288, 32'd1479};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 32'd1; tick();
        in_data = 32'd0; tick();
        tick();
        tick();
        in_data = 32'd0;         // second block A_0 held through compute/drain
        wait_out(lat);
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL b2b_latency got %0d exp 21", lat);
        end
        for (int k = 0; k < 4; k++) begin
            got[k] = out_valid ? out_data : 32'hdead_beef;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 32'd9217) begin
                errors++;
                $display("FAIL b2b_first_out%0d got %0d exp 9217", k, got[k]);
            end
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_rise got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
        end
        in_data = 32'd0; tick();
        in_data = 32'd4; tick();
        in_data = 32'd0; tick();
        in_data = 32'd0; tick();
        wait_out(lat);
        for (int k = 0; k < 4; k++) begin
            got[k] = out_valid ? out_data : 32'hdead_beef;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== exp2[k]) begin
                errors++;
                $display("FAIL b2b_second_out%0d got %0d exp %0d", k, got[k], exp2[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_twiddle();
        test_wrap();
        test_stall();
        test_reset_partial();
        test_reset_drain();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
